cbx_param: RTL and testbench

Parametrised X-channel connection block with a double-buffered configuration chain. It passes CHAN_WIDTH tracks straight through in both directions. It drives NUM_IPIN grid input pins, each through a MUX_SIZE-input mux that picks from a fixed, stride-based track pattern. Configuration bits shift in on the prog_clk scan chain into a shadow register and take effect only on an explicit commit, so the muxes never glitch during programming. The block replaces the fixed-size, single-buffered connection blocks in the routing fabric.

---
 rtl/cbx_param_if.sv | 28 ++
 rtl/cbx_param.sv | 133 +++++++++++++
 tb/tb_cbx_param.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cbx_param_if.sv
// Connection-block bus: config scan chain, status flags, channel tracks and ipin outputs.
// The slave modport is the connection block itself; the master side drives the chain.
interface cbx_param_if #(
  parameter int CHAN_WIDTH = 9,
  parameter int NUM_IPIN   = 3
);
  logic                  ccff_head;
  logic                  ccff_en;
  logic                  cfg_commit;
  logic [CHAN_WIDTH-1:0] chanx_left_in;
  logic [CHAN_WIDTH-1:0] chanx_right_in;
  logic [CHAN_WIDTH-1:0] chanx_left_out;
  logic [CHAN_WIDTH-1:0] chanx_right_out;
  logic [NUM_IPIN-1:0]   ipin_out;
  logic                  ccff_tail;
  logic                  cfg_ready;
  logic                  cfg_err;

  modport slave (
    input  ccff_head, ccff_en, cfg_commit, chanx_left_in, chanx_right_in,
    output chanx_left_out, chanx_right_out, ipin_out, ccff_tail, cfg_ready, cfg_err
  );

  modport master (
    output ccff_head, ccff_en, cfg_commit, chanx_left_in, chanx_right_in,
    input  chanx_left_out, chanx_right_out, ipin_out, ccff_tail, cfg_ready, cfg_err
  );
endinterface

// File: rtl/cbx_param.sv
// X-channel connection block: straight-through tracks, stride-pattern ipin muxes, scan-chain config.
// CBX_SHADOW_EN defined: shadow/active double buffer with commit; undefined: muxes follow the chain live.
module cbx_param #(
  parameter int CHAN_WIDTH = 9,
  parameter int NUM_IPIN   = 3,
  parameter int MUX_SIZE   = 6,
  parameter int STRIDE     = 4
) (
  input  logic prog_clk,
  input  logic prog_reset,
  cbx_param_if.slave bus
);
  localparam int SEL_W     = $clog2(MUX_SIZE);
  localparam int CHAIN_LEN = NUM_IPIN * SEL_W;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int NPAD      = 1 << SEL_W;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CHAIN_LEN);

  typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;

  state_t               state_q, state_d;
  logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [CHAIN_LEN-1:0] sel_src;
  logic                 commit_ok;
  logic                 commit_bad;

`ifdef CBX_SHADOW_EN
  logic [CHAIN_LEN-1:0] active_q;

  assign commit_ok  = bus.cfg_commit && (state_q == READY);
  assign commit_bad = bus.cfg_commit && (state_q != READY);
  assign sel_src    = active_q;

  // Active takes the pre-shift shadow even when a shift lands on the same edge.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      active_q <= '0;
    end else if (commit_ok) begin
      active_q <= shadow_q;
    end
  end
`else
  assign commit_ok  = 1'b0;
  assign commit_bad = 1'b0;
  assign sel_src    = shadow_q;
`endif

  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    err_d    = err_q | commit_bad;
    if (commit_ok) begin
      cnt_d = '0;
    end
    if (bus.ccff_en) begin
      shadow_d = {shadow_q[CHAIN_LEN-2:0], bus.ccff_head};
      if (cnt_d != FULL) begin
        cnt_d = cnt_d + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (bus.ccff_en) begin
          state_d = (cnt_d == FULL) ? READY : LOADING;
        end
      end
      LOADING: begin
        if (cnt_d == FULL) begin
          state_d = READY;
        end
      end
      READY: begin
        if (commit_ok) begin
          // A shift on the commit edge restarts the count at one.
          if (cnt_d == '0) begin
            state_d = EMPTY;
          end else begin
            state_d = (cnt_d == FULL) ? READY : LOADING;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q  <= EMPTY;
      shadow_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign bus.chanx_left_out  = bus.chanx_right_in;
  assign bus.chanx_right_out = bus.chanx_left_in;
  assign bus.ccff_tail       = shadow_q[CHAIN_LEN-1];
  assign bus.cfg_ready       = (state_q == READY);
  assign bus.cfg_err         = err_q;

  // Candidate list is padded to a power of two with zeros so out-of-range selects read 0.
  for (genvar i = 0; i < NUM_IPIN; i++) begin : g_ipin
    logic [NPAD-1:0]  cand;
    logic [SEL_W-1:0] sel;

    for (genvar k = 0; k < NPAD; k++) begin : g_cand
      if (k < MUX_SIZE) begin : g_trk
        localparam int T = (i + (k / 2) * STRIDE) % CHAN_WIDTH;
        if (k % 2 == 0) begin : g_left
          assign cand[k] = bus.chanx_left_in[T];
        end else begin : g_right
          assign cand[k] = bus.chanx_right_in[T];
        end
      end else begin : g_pad
        assign cand[k] = 1'b0;
      end
    end

    assign sel             = sel_src[i*SEL_W +: SEL_W];
    assign bus.ipin_out[i] = cand[sel];
  end
endmodule

// File: tb/tb_cbx_param.sv
// Randomized self-checking bench for cbx_param against a spec-level reference model.
module tb_cbx_param;
  localparam int CW = 9;
  localparam int NI = 3;
  localparam int MS = 6;
  localparam int ST = 4;
  localparam int SW = 3;
  localparam int CL = NI * SW;
`ifdef CBX_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic prog_clk   = 1'b0;
  logic prog_reset = 1'b0;

  cbx_param_if #(.CHAN_WIDTH(CW), .NUM_IPIN(NI)) bus ();

  cbx_param #(.CHAN_WIDTH(CW), .NUM_IPIN(NI), .MUX_SIZE(MS), .STRIDE(ST)) u_dut (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .bus        (bus)
  );

  always #5 prog_clk = ~prog_clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [CL-1:0] m_shadow;
  logic [CL-1:0] m_active;
  int            m_cnt;
  bit            m_err;

  function automatic logic [NI-1:0] exp_ipin(input logic [CL-1:0] src,
                                             input logic [CW-1:0] l,
                                             input logic [CW-1:0] r);
    logic [NI-1:0] o;
    int sel;
    int t;
    o = '0;
    for (int i = 0; i < NI; i++) begin
      sel = (int'(src) >> (i * SW)) % (1 << SW);
      if (sel >= MS) begin
        o[i] = 1'b0;
      end else begin
        t = (i + (sel / 2) * ST) % CW;
        o[i] = (sel % 2 == 1) ? r[t] : l[t];
      end
    end
    return o;
  endfunction

  function automatic logic [NI-1:0] model_ipin();
    return exp_ipin(SHADOW ? m_active : m_shadow, bus.chanx_left_in, bus.chanx_right_in);
  endfunction

  task automatic step(input bit h, input bit en, input bit cm, input bit rs);
    bus.ccff_head  = h;
    bus.ccff_en    = en;
    bus.cfg_commit = cm;
    prog_reset     = rs;
    @(posedge prog_clk);
    if (rs) begin
      m_shadow = '0;
      m_active = '0;
      m_cnt    = 0;
      m_err    = 1'b0;
    end else begin
      if (SHADOW && cm) begin
        if (m_cnt == CL) begin
          m_active = m_shadow;
          m_cnt    = 0;
        end else begin
          m_err = 1'b1;
        end
      end
      if (en) begin
        m_shadow = m_shadow * 2 + CL'(h);
        if (m_cnt < CL) m_cnt++;
      end
    end
    #1;
    bus.ccff_head  = 1'b0;
    bus.ccff_en    = 1'b0;
    bus.cfg_commit = 1'b0;
    prog_reset     = 1'b0;
  endtask

  task automatic rnd_chan();
    bus.chanx_left_in  = CW'($urandom);
    bus.chanx_right_in = CW'($urandom);
    #1;
  endtask

  task automatic load(input logic [CL-1:0] cfg);
    for (int n = CL - 1; n >= 0; n--) step(cfg[n], 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [CW-1:0] r;
    r = CW'($urandom);
    bus.chanx_left_in  = 9'h1A5;
    bus.chanx_right_in = r;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    checks++; if (bus.chanx_right_out !== 9'h1A5) begin errors++; $display("FAIL reset_right_out: got %h want %h", bus.chanx_right_out, 9'h1A5); end
    checks++; if (bus.chanx_left_out !== r) begin errors++; $display("FAIL reset_left_out: got %h want %h", bus.chanx_left_out, r); end
    checks++; if (bus.ipin_out[0] !== 1'b1) begin errors++; $display("FAIL reset_ipin0: got %b want 1", bus.ipin_out[0]); end
    checks++; if (bus.ipin_out !== model_ipin()) begin errors++; $display("FAIL reset_ipin: got %b want %b", bus.ipin_out, model_ipin()); end
    checks++; if (bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.cfg_ready); end
    checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.cfg_err); end
    checks++; if (bus.ccff_tail !== 1'b0) begin errors++; $display("FAIL reset_tail: got %b want 0", bus.ccff_tail); end
  endtask

  task automatic test_load_commit();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    load(9'b000_000_010);
    rnd_chan();
    checks++; if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b want 1", bus.cfg_ready); end
    checks++; if (bus.ipin_out !== model_ipin()) begin errors++; $display("FAIL load_precommit_ipin: got %b want %b", bus.ipin_out, model_ipin()); end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    rnd_chan();
    checks++; if (bus.ipin_out[0] !== bus.chanx_left_in[4]) begin errors++; $display("FAIL commit_ipin0: got %b want %b", bus.ipin_out[0], bus.chanx_left_in[4]); end
    checks++; if (bus.ipin_out !== model_ipin()) begin errors++; $display("FAIL commit_ipin: got %b want %b", bus.ipin_out, model_ipin()); end
    checks++; if (bus.cfg_ready !== (m_cnt == CL)) begin errors++; $display("FAIL commit_ready: got %b want %b", bus.cfg_ready, (m_cnt == CL)); end
  endtask

  task automatic test_early_commit();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++) step(1'($urandom), 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    rnd_chan();
    checks++; if (bus.cfg_err !== m_err) begin errors++; $display("FAIL early_err: got %b want %b", bus.cfg_err, m_err); end
    checks++; if (bus.ipin_out !== model_ipin()) begin errors++; $display("FAIL early_ipin: got %b want %b", bus.ipin_out, model_ipin()); end
    checks++; if (bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL early_ready: got %b want 0", bus.cfg_ready); end
    for (int n = 0; n < 4; n++) step(1'($urandom), 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    rnd_chan();
    checks++; if (bus.cfg_err !== m_err) begin errors++; $display("FAIL late_err: got %b want %b", bus.cfg_err, m_err); end
    checks++; if (bus.ipin_out !== model_ipin()) begin errors++; $display("FAIL late_ipin: got %b want %b", bus.ipin_out, model_ipin()); end
    checks++; if (bus.cfg_ready !== (m_cnt == CL)) begin errors++; $display("FAIL late_ready: got %b want %b", bus.cfg_ready, (m_cnt == CL)); end
  endtask

  task automatic test_oob();
    logic [CL-1:0] cfg;
    cfg = {3'b111, 6'($urandom)};
    step(1'b0, 1'b0, 1'b0, 1'b1);
    load(cfg);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 8; n++) begin
      rnd_chan();
      checks++; if (bus.ipin_out[2] !== 1'b0) begin errors++; $display("FAIL oob_ipin2: got %b want 0", bus.ipin_out[2]); end
      checks++; if (bus.ipin_out !== model_ipin()) begin errors++; $display("FAIL oob_ipin: got %b want %b", bus.ipin_out, model_ipin()); end
    end
  endtask

  task automatic test_daisy();
    bit pat [12];
    bit exp_tail;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;
    for (int n = 4; n < 12; n++) pat[n] = 1'($urandom);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int s = 1; s <= 12; s++) begin
      step(pat[s-1], 1'b1, 1'b0, 1'b0);
      exp_tail = (s >= CL) ? pat[s-CL] : 1'b0;
      checks++; if (bus.ccff_tail !== exp_tail) begin errors++; $display("FAIL daisy_tail s=%0d: got %b want %b", s, bus.ccff_tail, exp_tail); end
      checks++; if (bus.cfg_ready !== (s >= CL)) begin errors++; $display("FAIL daisy_ready s=%0d: got %b want %b", s, bus.cfg_ready, (s >= CL)); end
    end
  endtask

  task automatic test_reset_midload();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    rnd_chan();
    checks++; if (bus.cfg_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b want 0", bus.cfg_ready); end
    checks++; if (bus.ccff_tail !== 1'b0) begin errors++; $display("FAIL midrst_tail: got %b want 0", bus.ccff_tail); end
    checks++; if (bus.ipin_out !== exp_ipin('0, bus.chanx_left_in, bus.chanx_right_in)) begin errors++; $display("FAIL midrst_ipin: got %b want %b", bus.ipin_out, exp_ipin('0, bus.chanx_left_in, bus.chanx_right_in)); end
    load(CL'($urandom));
    checks++; if (bus.cfg_ready !== 1'b1) begin errors++; $display("FAIL reload_ready: got %b want 1", bus.cfg_ready); end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    rnd_chan();
    checks++; if (bus.ipin_out !== model_ipin()) begin errors++; $display("FAIL reload_ipin: got %b want %b", bus.ipin_out, model_ipin()); end
  endtask

  task automatic test_commit_shift();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    load(CL'($urandom));
    step(1'($urandom), 1'b1, 1'b1, 1'b0);
    rnd_chan();
    checks++; if (bus.cfg_ready !== (m_cnt == CL)) begin errors++; $display("FAIL cs_ready: got %b want %b", bus.cfg_ready, (m_cnt == CL)); end
    checks++; if (bus.ipin_out !== model_ipin()) begin errors++; $display("FAIL cs_ipin: got %b want %b", bus.ipin_out, model_ipin()); end
    checks++; if (bus.ccff_tail !== m_shadow[CL-1]) begin errors++; $display("FAIL cs_tail: got %b want %b", bus.ccff_tail, m_shadow[CL-1]); end
    checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL cs_err: got %b want 0", bus.cfg_err); end
  endtask

  task automatic test_back_to_back();
    bit rs;
    bit en;
    bit cm;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 300; n++) begin
      rs = ($urandom % 40) == 0;
      en = ($urandom % 4) != 0;
      cm = ($urandom % 8) == 0;
      step(1'($urandom), en, cm, rs);
      rnd_chan();
      checks++; if (bus.ipin_out !== model_ipin()) begin errors++; $display("FAIL b2b_ipin n=%0d: got %b want %b", n, bus.ipin_out, model_ipin()); end
      checks++; if (bus.cfg_ready !== (m_cnt == CL)) begin errors++; $display("FAIL b2b_ready n=%0d: got %b want %b", n, bus.cfg_ready, (m_cnt == CL)); end
      checks++; if (bus.cfg_err !== m_err) begin errors++; $display("FAIL b2b_err n=%0d: got %b want %b", n, bus.cfg_err, m_err); end
      checks++; if (bus.ccff_tail !== m_shadow[CL-1]) begin errors++; $display("FAIL b2b_tail n=%0d: got %b want %b", n, bus.ccff_tail, m_shadow[CL-1]); end
      checks++; if (bus.chanx_right_out !== bus.chanx_left_in) begin errors++; $display("FAIL b2b_pass n=%0d: got %h want %h", n, bus.chanx_right_out, bus.chanx_left_in); end
    end
  endtask

  initial begin
    bus.ccff_head      = 1'b0;
    bus.ccff_en        = 1'b0;
    bus.cfg_commit     = 1'b0;
    bus.chanx_left_in  = '0;
    bus.chanx_right_in = '0;
    m_shadow = '0;
    m_active = '0;
    m_cnt    = 0;
    m_err    = 1'b0;
    #2;
    test_reset();
    test_load_commit();
    test_early_commit();
    test_oob();
    test_daisy();
    test_reset_midload();
    test_commit_shift();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
